// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline state encoding, default lane width and occupancy helper
package pipe_pkg;
  localparam int DATA_WIDTH_DEFAULT = 32;
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  function automatic logic [1:0] occupancy(state_t s);
    return (s == FULL) ? 2'd2 : (s == BUSY) ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/pipe_skid_stage_if.sv
// pipe_skid_stage_if: upstream/downstream handshake, payload and control of one skid stage
interface pipe_skid_stage_if
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int NUM_LANES  = 2
);
  logic                          i_Flush;
  logic                          i_Freeze;
  logic                          i_Valid;
  logic [NUM_LANES*DATA_WIDTH-1:0] i_Data;
  logic                          o_Ready;
  logic                          o_Valid;
  logic [NUM_LANES*DATA_WIDTH-1:0] o_Data;
  logic                          i_Ready;
  logic [1:0]                    o_Occupancy;
  modport master (
    output i_Flush, i_Freeze, i_Valid, i_Data, i_Ready,
    input  o_Ready, o_Valid, o_Data, o_Occupancy
  );
  modport slave (
    input  i_Flush, i_Freeze, i_Valid, i_Data, i_Ready,
    output o_Ready, o_Valid, o_Data, o_Occupancy
  );
endinterface

// File: rtl/pipe_slot.sv
// pipe_slot: payload register with load, clear (wins over load) and hold
module pipe_slot #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk) begin
    if (reset || i_clear) r_q <= '0;
    else if (i_load) r_q <= i_d;
  end
  assign o_q = r_q;
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer with registered ready-independent output, flush and freeze
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int NUM_LANES  = 2
) (
  input logic               clk,
  input logic               reset,
  pipe_skid_stage_if.slave  bus
);
  localparam int W = NUM_LANES * DATA_WIDTH;
  state_t       r_state, w_next;
  logic [W-1:0] w_main_q, w_skid_q, w_main_d;
  logic         w_ready, w_valid, w_accept, w_release;
  logic         w_main_load, w_main_clear, w_skid_load, w_skid_clear;
  assign w_ready   = (r_state != FULL) & ~bus.i_Freeze;
  assign w_valid   = (r_state != EMPTY);
  assign w_accept  = bus.i_Valid & w_ready & ~bus.i_Flush;
  assign w_release = w_valid & bus.i_Ready & ~bus.i_Freeze & ~bus.i_Flush;
  always_ff @(posedge clk) begin
    if (reset) r_state <= EMPTY;
    else r_state <= w_next;
  end
  always_comb begin
    w_next       = r_state;
    w_main_load  = 1'b0;
    w_main_clear = bus.i_Flush;
    w_main_d     = bus.i_Data;
    w_skid_load  = 1'b0;
    w_skid_clear = bus.i_Flush;
    if (bus.i_Flush) w_next = EMPTY;
    else begin
      case (r_state)
        EMPTY: begin
          w_next      = w_accept ? BUSY : EMPTY;
          w_main_load = w_accept;
        end
        BUSY: begin
          w_next       = (w_accept & ~w_release) ? FULL : (~w_accept & w_release) ? EMPTY : BUSY;
          w_main_load  = w_accept & w_release;
          w_skid_load  = w_accept & ~w_release;
          w_main_clear = ~w_accept & w_release;
        end
        FULL: begin
          w_next       = w_release ? BUSY : FULL;
          w_main_load  = w_release;
          w_main_d     = w_skid_q;
          w_skid_clear = w_release;
        end
        default: w_next = EMPTY;
      endcase
    end
  end
  pipe_slot #(.W(W)) u_main (
    .clk(clk), .reset(reset), .i_load(w_main_load), .i_clear(w_main_clear),
    .i_d(w_main_d), .o_q(w_main_q)
  );
  pipe_slot #(.W(W)) u_skid (
    .clk(clk), .reset(reset), .i_load(w_skid_load), .i_clear(w_skid_clear),
    .i_d(bus.i_Data), .o_q(w_skid_q)
  );
  assign bus.o_Ready     = w_ready;
  assign bus.o_Valid     = w_valid;
  assign bus.o_Data      = w_main_q;
  assign bus.o_Occupancy = occupancy(r_state);
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed vectors with a queue scoreboard checked at every falling edge
module tb_pipe_skid_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  pipe_skid_stage_if #(.DATA_WIDTH(32), .NUM_LANES(2)) bus ();
  pipe_skid_stage #(.DATA_WIDTH(32), .NUM_LANES(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  logic [63:0] q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  bit  armed = 1'b0;
  bit  last_acc = 1'b0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (armed) begin
      chk("o_Valid", {63'd0, bus.o_Valid}, {63'd0, q.size() != 0});
      chk("o_Occupancy", {62'd0, bus.o_Occupancy}, 64'(q.size()));
      chk("o_Ready", {63'd0, bus.o_Ready}, {63'd0, (q.size() != 2) & ~bus.i_Freeze});
      chk("o_Data", bus.o_Data, (q.size() != 0) ? q[0] : 64'd0);
    end
    last_acc = 1'b0;
    if (reset || bus.i_Flush) begin
      q.delete();
      armed = armed | reset;
    end else begin
      automatic bit acc = bus.i_Valid & (q.size() != 2) & ~bus.i_Freeze;
      automatic bit rel = (q.size() != 0) & bus.i_Ready & ~bus.i_Freeze;
      if (rel) void'(q.pop_front());
      if (acc) q.push_back(bus.i_Data);
      last_acc = acc;
    end
  end
  task automatic drive(bit v, logic [63:0] d, bit r, bit fz, bit fl, bit rs);
    bus.i_Valid  = v;
    bus.i_Data   = d;
    bus.i_Ready  = r;
    bus.i_Freeze = fz;
    bus.i_Flush  = fl;
    reset        = rs;
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 64'h0000_0004_E3A0_1005, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 64'hA, 0, 0, 0, 0);
    drive(1, 64'hB, 0, 0, 0, 0);
    drive(1, 64'hC, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 64'hA, 0, 0, 0, 0);
    drive(1, 64'hB, 0, 0, 0, 0);
    drive(1, 64'hC, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 64'h5, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 64'h99, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 64'h7, 0, 0, 0, 0);
    drive(1, 64'h8, 0, 0, 0, 0);
    drive(1, 64'h9, 1, 1, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(1, 64'h100 + 64'(i), 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    begin
      automatic int i = 1;
      automatic int guard = 0;
      automatic bit r = 1'b0;
      while (i <= 16 && guard < 200) begin
        drive(1, 64'(i), r, 0, 0, 0);
        if (last_acc) i++;
        r = ~r;
        guard++;
      end
      n_chk++;
      if (i <= 16) begin
        n_fail++;
        $display("FAIL stream_timeout: got %0d accepted expected 16", i - 1);
      end
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, 0);
    drive(1, 64'hDEAD, 0, 0, 0, 0);
    drive(1, 64'hBEEF, 0, 0, 0, 0);
    drive(1, 64'hF00D, 1, 1, 1, 1);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
